// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: issues one word fetch at a time to the cache
// instruction port and buffers the returned words, tagged with their PC, in
// a small FIFO for decode. Redirects flush the queue and discard any fetch
// still in flight.
// Optional feature macro: IFQ_BYPASS_EN. When it is defined, a word returning
// into an empty queue is presented to decode combinationally in its arrival
// cycle.

`ifndef IF_FINISHED
`define IF_FINISHED 2'b10
`endif

module inst_fetch_queue #(
  parameter int ADDR_WIDTH  = 17,
  parameter int LEN         = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int PTR_WIDTH   = 2,
  parameter int RESET_PC    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  inst_fetch_enabled,
  output logic [ADDR_WIDTH-1:0] mem_inst_addr,
  input  logic [LEN-1:0]        instruction,
  input  logic [1:0]            mem_vis_status,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  deq_ready,
  output logic                  deq_valid,
  output logic [LEN-1:0]        deq_inst,
  output logic [ADDR_WIDTH-1:0] deq_pc,
  output logic [PTR_WIDTH:0]    queue_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_W = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [PTR_WIDTH-1:0]  PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]    CNT_ONE    = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH+1:0]  DEPTH_W    = (PTR_WIDTH+2)'(QUEUE_DEPTH);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                    en_q, en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]      count_q, count_d;

  // FIFO storage is pure data and is never reset; validity comes from count_q.
  logic [LEN-1:0]          fifo_inst_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_pc_q   [QUEUE_DEPTH];

  logic                    fin;
  logic                    head_valid;
  logic                    bypass;
  logic                    deq_fire;
  logic                    push;
  logic                    pop;
  logic [PTR_WIDTH+1:0]    occ_with_fire;
  logic                    space_ok;

  assign fin        = (mem_vis_status == `IF_FINISHED);
  assign head_valid = (count_q != '0);

`ifdef IFQ_BYPASS_EN
  // A word arriving for a live fetch into an empty queue goes straight to decode.
  assign bypass = !head_valid && (state_q == S_WAIT) && fin && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid   = head_valid | bypass;
  assign deq_fire    = deq_valid & deq_ready;
  assign queue_count = count_q;

  // A redirect flushes the queue, so a pop in the same cycle is meaningless.
  assign pop  = deq_ready & head_valid & ~redirect_valid;
  // Live returned word is stored unless the bypass path already handed it over.
  assign push = (state_q == S_WAIT) & fin & ~redirect_valid & ~(bypass & deq_ready);

  // Issue is conservative: a slot must be free even counting this cycle's pop.
  assign occ_with_fire = {1'b0, count_q} + {{(PTR_WIDTH+1){1'b0}}, deq_fire};
  assign space_ok      = (occ_with_fire < DEPTH_W);

  // Decode-side view of the head entry (or the bypassed word); zero when idle.
  always_comb begin
    deq_inst = '0;
    deq_pc   = '0;
    if (head_valid) begin
      deq_inst = fifo_inst_q[rd_ptr_q];
      deq_pc   = fifo_pc_q[rd_ptr_q];
    end else if (bypass) begin
      deq_inst = instruction;
      deq_pc   = fetch_pc_q;
    end
  end

  // Fetch FSM: request is held stable from issue until the cache reports completion.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    en_d       = en_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && space_ok) begin
          en_d    = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fin) begin
          en_d    = 1'b0;
          state_d = S_IDLE;
          if (!redirect_valid) fetch_pc_d = fetch_pc_q + PC_STEP;
        end else if (redirect_valid) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (fin) begin
          en_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  // Queue pointer and occupancy bookkeeping; a redirect empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC_W;
      en_q       <= 1'b0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO write port: store the returned word together with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= instruction;
      fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign inst_fetch_enabled = en_q;
  assign mem_inst_addr      = addr_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: a small cache model answers fetches, and a
// queue-based reference model predicts requests, occupancy and the head entry.

`ifndef IF_FINISHED
`define IF_FINISHED 2'b10
`endif

module tb_inst_fetch_queue;
  localparam int AW = 17;
  localparam int LW = 32;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FETCH = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inst_fetch_enabled;
  logic [AW-1:0] mem_inst_addr;
  logic [LW-1:0] instruction;
  logic [1:0]    mem_vis_status;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          deq_ready;
  logic          deq_valid;
  logic [LW-1:0] deq_inst;
  logic [AW-1:0] deq_pc;
  logic [2:0]    queue_count;

  always #5 clk = ~clk;

  inst_fetch_queue dut (
    .clk(clk), .rst_n(rst_n),
    .inst_fetch_enabled(inst_fetch_enabled), .mem_inst_addr(mem_inst_addr),
    .instruction(instruction), .mem_vis_status(mem_vis_status),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .queue_count(queue_count)
  );

  typedef struct { logic [AW-1:0] pc; logic [LW-1:0] inst; } entry_t;

  // Reference model: queue contents, next fetch PC, outstanding request.
  entry_t        q[$];
  logic [AW-1:0] m_pc, m_addr;
  bit            m_req, m_stale;

  // Cache model state.
  bit            c_pend;
  int            c_cnt, c_busy, c_lat, c_busy_rate;
  logic [AW-1:0] c_addr;
  bit            inst_const;

  int checks = 0;
  int errors = 0;

  function automatic logic [LW-1:0] inst_of(input logic [AW-1:0] a);
    return inst_const ? 32'h0000_0013 : {a, 15'h0013};
  endfunction

  function automatic bit model_bypass();
`ifdef IFQ_BYPASS_EN
    return (q.size() == 0) && m_req && !m_stale &&
           (mem_vis_status == `IF_FINISHED) && !redirect_valid;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_head(output bit v, output logic [LW-1:0] i, output logic [AW-1:0] p);
    v = 0; i = '0; p = '0;
    if (q.size() > 0) begin
      v = 1; i = q[0].inst; p = q[0].pc;
    end else if (model_bypass()) begin
      v = 1; i = instruction; p = m_pc;
    end
  endtask

  // Advance the model by one clock edge using the inputs present this cycle.
  task automatic model_step();
    bit fin; int sz; bit byp; bit fire;
    fin  = (mem_vis_status == `IF_FINISHED);
    sz   = q.size();
    byp  = model_bypass();
    fire = deq_ready && (sz > 0 || byp);
    if (redirect_valid) begin
      q.delete();
      if (m_req && fin) begin
        m_req = 0; m_stale = 0;
      end else if (m_req) begin
        m_stale = 1;
      end
      m_pc = redirect_pc;
    end else begin
      if (deq_ready && sz > 0) void'(q.pop_front());
      if (m_req && fin) begin
        if (!m_stale) begin
          if (!(byp && deq_ready)) q.push_back('{pc: m_pc, inst: instruction});
          m_pc = m_pc + 17'd4;
        end
        m_req = 0; m_stale = 0;
      end else if (!m_req && (sz + int'(fire) < 4)) begin
        m_req = 1; m_addr = m_pc;
      end
    end
  endtask

  // Cache: accepts a request only when idle; may be busy with data traffic.
  task automatic cache_drive();
    instruction = $urandom;
    if (c_pend) begin
      if (c_cnt <= 1) begin
        mem_vis_status = `IF_FINISHED;
        instruction    = inst_of(c_addr);
        c_pend         = 0;
      end else begin
        c_cnt--;
        mem_vis_status = ST_FETCH;
      end
    end else if (c_busy > 0) begin
      c_busy--;
      mem_vis_status = ST_BUSY;
    end else if (inst_fetch_enabled) begin
      c_pend = 1;
      c_addr = mem_inst_addr;
      c_cnt  = (c_lat == 0) ? $urandom_range(1, 6) : c_lat;
      mem_vis_status = ST_FETCH;
    end else begin
      mem_vis_status = ST_IDLE;
      if (c_busy_rate > 0 && $urandom_range(0, 99) < c_busy_rate)
        c_busy = $urandom_range(1, 4);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    redirect_valid = 0;
    cache_drive();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; redirect_valid = 0; redirect_pc = '0; deq_ready = 0;
    mem_vis_status = ST_IDLE; instruction = '0;
    q.delete(); m_pc = '0; m_addr = '0; m_req = 0; m_stale = 0;
    c_pend = 0; c_cnt = 0; c_busy = 0; c_lat = 6; c_busy_rate = 0; inst_const = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (inst_fetch_enabled !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", inst_fetch_enabled); end
    checks++; if (mem_inst_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_inst_addr); end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid); end
    checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", queue_count); end
    checks++; if (deq_inst !== '0 || deq_pc !== '0) begin errors++; $display("FAIL reset_deq_data: got %h/%h want 0/0", deq_inst, deq_pc); end
    @(negedge clk);
    rst_n = 1;
    cycle();
  endtask

  task automatic test_first_fetch();
    bit ok;
    checks++; if (inst_fetch_enabled !== 1'b1 || mem_inst_addr !== 17'h0) begin errors++; $display("FAIL t1_req0: got en=%b addr=%h want en=1 addr=00000", inst_fetch_enabled, mem_inst_addr); end
    ok = 0;
    for (int i = 0; i < 20; i++) begin if (queue_count === 3'd1) begin ok = 1; break; end cycle(); end
    checks++; if (!ok) begin errors++; $display("FAIL t1_wait_word0: got count=%0d want 1 within 20 cycles", queue_count); end
    checks++; if (deq_valid !== 1'b1 || deq_pc !== 17'h0 || deq_inst !== 32'h13) begin errors++; $display("FAIL t1_head0: got v=%b pc=%h inst=%h want v=1 pc=00000 inst=00000013", deq_valid, deq_pc, deq_inst); end
    ok = 0;
    for (int i = 0; i < 5; i++) begin if (inst_fetch_enabled === 1'b1) begin ok = 1; break; end cycle(); end
    checks++; if (!ok || mem_inst_addr !== 17'h4) begin errors++; $display("FAIL t1_req1: got en=%b addr=%h want en=1 addr=00004", inst_fetch_enabled, mem_inst_addr); end
  endtask

  task automatic test_full_queue();
    bit ok; bit held;
    ok = 0;
    for (int i = 0; i < 80; i++) begin if (queue_count === 3'd4) begin ok = 1; break; end cycle(); end
    checks++; if (!ok) begin errors++; $display("FAIL t2_fill: got count=%0d want 4 within 80 cycles", queue_count); end
    held = 1;
    for (int i = 0; i < 15; i++) begin cycle(); if (inst_fetch_enabled !== 1'b0) held = 0; end
    checks++; if (!held) begin errors++; $display("FAIL t2_no_req_when_full: got en=1 want en=0 while full"); end
    checks++; if (deq_pc !== 17'h0) begin errors++; $display("FAIL t2_head_before_pop: got %h want 00000", deq_pc); end
    deq_ready = 1;
    cycle();
    deq_ready = 0;
    checks++; if (queue_count !== 3'd3 || deq_pc !== 17'h4) begin errors++; $display("FAIL t2_pop: got count=%0d pc=%h want count=3 pc=00004", queue_count, deq_pc); end
    ok = 0;
    for (int i = 0; i < 5; i++) begin if (inst_fetch_enabled === 1'b1) begin ok = 1; break; end cycle(); end
    checks++; if (!ok || mem_inst_addr !== 17'h10) begin errors++; $display("FAIL t2_req_after_pop: got en=%b addr=%h want en=1 addr=00010", inst_fetch_enabled, mem_inst_addr); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    redirect_valid = 1; redirect_pc = 17'h00100;
    cycle();
    checks++; if (queue_count !== 3'd0 || deq_valid !== 1'b0) begin errors++; $display("FAIL t3_flush: got count=%0d v=%b want 0/0", queue_count, deq_valid); end
    ok = 0;
    for (int i = 0; i < 20; i++) begin if (inst_fetch_enabled === 1'b0) begin ok = 1; break; end cycle(); end
    checks++; if (!ok || queue_count !== 3'd0) begin errors++; $display("FAIL t3_stale_dropped: got en=%b count=%0d want 0/0", inst_fetch_enabled, queue_count); end
    ok = 0;
    for (int i = 0; i < 5; i++) begin if (inst_fetch_enabled === 1'b1) begin ok = 1; break; end cycle(); end
    checks++; if (!ok || mem_inst_addr !== 17'h00100) begin errors++; $display("FAIL t3_req_redirect: got en=%b addr=%h want en=1 addr=00100", inst_fetch_enabled, mem_inst_addr); end
    ok = 0;
    for (int i = 0; i < 20; i++) begin if (queue_count === 3'd1) begin ok = 1; break; end cycle(); end
    checks++; if (!ok || deq_pc !== 17'h00100) begin errors++; $display("FAIL t3_word: got count=%0d pc=%h want 1/00100", queue_count, deq_pc); end
  endtask

  task automatic test_redirect_finish_pop();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin if (mem_vis_status === `IF_FINISHED) begin ok = 1; break; end cycle(); end
    checks++; if (!ok) begin errors++; $display("FAIL t4_wait_finish: got status=%b want finished within 20 cycles", mem_vis_status); end
    redirect_valid = 1; redirect_pc = 17'h002A0; deq_ready = 1;
    cycle();
    deq_ready = 0;
    checks++; if (queue_count !== 3'd0 || deq_valid !== 1'b0 || inst_fetch_enabled !== 1'b0) begin errors++; $display("FAIL t4_flush: got count=%0d v=%b en=%b want 0/0/0", queue_count, deq_valid, inst_fetch_enabled); end
    ok = 0;
    for (int i = 0; i < 5; i++) begin if (inst_fetch_enabled === 1'b1) begin ok = 1; break; end cycle(); end
    checks++; if (!ok || mem_inst_addr !== 17'h002A0) begin errors++; $display("FAIL t4_req: got en=%b addr=%h want en=1 addr=002a0", inst_fetch_enabled, mem_inst_addr); end
  endtask

  task automatic test_cache_busy();
    bit ok; bit held;
    inst_const = 0;
    redirect_valid = 1; redirect_pc = 17'h00400;
    cycle();
    ok = 0;
    for (int i = 0; i < 20; i++) begin if (inst_fetch_enabled === 1'b0 && !c_pend) begin ok = 1; break; end cycle(); end
    checks++; if (!ok) begin errors++; $display("FAIL t5_wait_idle: got en=%b want 0 within 20 cycles", inst_fetch_enabled); end
    c_busy = 5;
    held = 1; ok = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (inst_fetch_enabled !== 1'b1 || mem_inst_addr !== 17'h00400) held = 0;
      if (mem_vis_status === `IF_FINISHED) begin ok = 1; break; end
    end
    checks++; if (!held) begin errors++; $display("FAIL t5_req_stable: got en=%b addr=%h want en=1 addr=00400 throughout", inst_fetch_enabled, mem_inst_addr); end
    checks++; if (!ok) begin errors++; $display("FAIL t5_finish: got status=%b want finished within 40 cycles", mem_vis_status); end
    cycle();
    checks++; if (queue_count !== 3'd1 || deq_pc !== 17'h00400 || deq_inst !== inst_of(17'h00400)) begin errors++; $display("FAIL t5_word: got count=%0d pc=%h inst=%h want 1/00400/%h", queue_count, deq_pc, deq_inst, inst_of(17'h00400)); end
  endtask

  task automatic test_wrap();
    bit ok; bit byp;
`ifdef IFQ_BYPASS_EN
    byp = 1;
`else
    byp = 0;
`endif
    deq_ready = byp;
    redirect_valid = 1; redirect_pc = 17'h1FFFC;
    cycle();
    ok = 0;
    for (int i = 0; i < 30; i++) begin if (inst_fetch_enabled === 1'b1 && mem_inst_addr === 17'h1FFFC) begin ok = 1; break; end cycle(); end
    checks++; if (!ok) begin errors++; $display("FAIL t6_req_top: got en=%b addr=%h want en=1 addr=1fffc", inst_fetch_enabled, mem_inst_addr); end
    ok = 0;
    for (int i = 0; i < 20; i++) begin if (mem_vis_status === `IF_FINISHED) begin ok = 1; break; end cycle(); end
    checks++; if (!ok) begin errors++; $display("FAIL t6_wait_finish: got status=%b want finished", mem_vis_status); end
    if (byp) begin
      checks++; if (deq_valid !== 1'b1 || deq_pc !== 17'h1FFFC || deq_inst !== inst_of(17'h1FFFC)) begin errors++; $display("FAIL t6_bypass: got v=%b pc=%h inst=%h want 1/1fffc/%h", deq_valid, deq_pc, deq_inst, inst_of(17'h1FFFC)); end
      cycle();
      checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL t6_bypass_count: got %0d want 0", queue_count); end
    end else begin
      checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL t6_no_early_valid: got %b want 0", deq_valid); end
      cycle();
      checks++; if (queue_count !== 3'd1 || deq_pc !== 17'h1FFFC) begin errors++; $display("FAIL t6_word: got count=%0d pc=%h want 1/1fffc", queue_count, deq_pc); end
    end
    ok = 0;
    for (int i = 0; i < 5; i++) begin if (inst_fetch_enabled === 1'b1) begin ok = 1; break; end cycle(); end
    checks++; if (!ok || mem_inst_addr !== 17'h00000) begin errors++; $display("FAIL t6_wrap: got en=%b addr=%h want en=1 addr=00000", inst_fetch_enabled, mem_inst_addr); end
    deq_ready = 0;
  endtask

  task automatic test_random();
    bit ev; logic [LW-1:0] ei; logic [AW-1:0] ep;
    c_lat = 0; c_busy_rate = 10;
    for (int n = 0; n < 3000; n++) begin
      deq_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1;
        redirect_pc = AW'($urandom);
      end
      cycle();
      model_head(ev, ei, ep);
      checks++; if (inst_fetch_enabled !== m_req) begin errors++; $display("FAIL rnd_en @%0d: got %b want %b", n, inst_fetch_enabled, m_req); end
      checks++; if (m_req && mem_inst_addr !== m_addr) begin errors++; $display("FAIL rnd_addr @%0d: got %h want %h", n, mem_inst_addr, m_addr); end
      checks++; if (queue_count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count @%0d: got %0d want %0d", n, queue_count, q.size()); end
      checks++; if (deq_valid !== ev) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", n, deq_valid, ev); end
      checks++; if (ev && (deq_inst !== ei || deq_pc !== ep)) begin errors++; $display("FAIL rnd_head @%0d: got %h/%h want %h/%h", n, deq_inst, deq_pc, ei, ep); end
    end
    deq_ready = 0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_full_queue();
    test_redirect_wait();
    test_redirect_finish_pop();
    test_cache_busy();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
